// File: rtl/coin_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : coin_event_arbiter
// Purpose  : Collects one-cycle coin-detect pulses from four coin sources into
//            per-source saturating pending counters and presents them one at
//            a time as valid/ready coin events, using round-robin arbitration.
//            Lost coins (counter saturated) raise a sticky ovf flag; coins
//            arriving while acceptance is disabled produce a reject pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1  sole clock, rising edge
//   rst         in   1  synchronous active-high reset
//   coin_pulse  in   4  coin-detect pulses; bit0=1, bit1=2, bit2=5, bit3=10
//   accept_en   in   1  1 = accept coins, 0 = reject coins
//   ev_ready    in   1  downstream accepts the presented event
//   ovf_clr     in   1  pulse clearing all ovf flags
//   ev_valid    out  1  event presented
//   ev_src      out  2  source index of presented event (0 while empty)
//   ev_value    out  4  coin value of presented event (0 while empty)
//   rej_pulse   out  4  one-cycle reject pulse per source
//   ovf         out  4  sticky per-source overflow flags
//   busy        out  1  any pending count non-zero or event presented
// ============================================================================
module coin_event_arbiter #(
    parameter int PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coin_pulse,
    input  logic       accept_en,
    input  logic       ev_ready,
    input  logic       ovf_clr,
    output logic       ev_valid,
    output logic [1:0] ev_src,
    output logic [3:0] ev_value,
    output logic [3:0] rej_pulse,
    output logic [3:0] ovf,
    output logic       busy
);

    localparam logic [PEND_W-1:0] c_cnt_max = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] c_cnt_one = {{(PEND_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q;
    logic [1:0]        ev_src_q;
    logic [3:0]        ev_value_q;
    logic [1:0]        last_grant_q;
    logic [3:0]        rej_q;
    logic [3:0]        ovf_q;
    logic [3:0]        ovf_d;
    logic [PEND_W-1:0] cnt_q [4];
    logic [PEND_W-1:0] cnt_d [4];

    logic [3:0]        pending;
    logic [3:0]        ovf_set;
    logic [3:0]        dec;
    logic [1:0]        sel;
    logic              sel_found;
    logic              load;

    // Fixed coin value per source index.
    function automatic logic [3:0] coin_value(input logic [1:0] src);
        case (src)
            2'd0:    coin_value = 4'd1;
            2'd1:    coin_value = 4'd2;
            2'd2:    coin_value = 4'd5;
            default: coin_value = 4'd10;
        endcase
    endfunction

    // Round-robin search beginning just after the last granted source.
    always_comb begin
        sel       = 2'd0;
        sel_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] idx;
            idx = last_grant_q + 2'(k);
            if (!sel_found && pending[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    // A new event may enter the output register when it is free or being
    // consumed this cycle; decisions use registered counts only.
    assign load = ((state_q == ST_EMPTY) || ev_ready) && sel_found;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_src
            logic inc;
            logic sat;

            assign pending[i] = (cnt_q[i] != '0);
            assign dec[i]     = load && (sel == 2'(i));
            assign inc        = coin_pulse[i] && accept_en;
            assign sat        = (cnt_q[i] == c_cnt_max);

            // A simultaneous increment and decrement cancel, so a saturated
            // counter being drained this cycle does not lose the new coin.
            always_comb begin
                cnt_d[i]   = cnt_q[i];
                ovf_set[i] = 1'b0;
                if (inc && !dec[i]) begin
                    if (sat) begin
                        ovf_set[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + c_cnt_one;
                    end
                end else if (dec[i] && !inc) begin
                    cnt_d[i] = cnt_q[i] - c_cnt_one;
                end
            end
        end
    endgenerate

    // Clear wins over stale flags, but a fresh overflow in the clear cycle
    // still sets its bit.
    assign ovf_d = (ovf_q & {4{~ovf_clr}}) | ovf_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q <= 4'd0;
            rej_q <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q <= ovf_d;
            rej_q <= coin_pulse & {4{~accept_en}};
        end
    end

    // Output stage FSM with registered event fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            ev_src_q     <= 2'd0;
            ev_value_q   <= 4'd0;
            last_grant_q <= 2'd3;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (load) begin
                        state_q      <= ST_FULL;
                        ev_src_q     <= sel;
                        ev_value_q   <= coin_value(sel);
                        last_grant_q <= sel;
                    end
                end
                ST_FULL: begin
                    if (ev_ready) begin
                        if (load) begin
                            ev_src_q     <= sel;
                            ev_value_q   <= coin_value(sel);
                            last_grant_q <= sel;
                        end else begin
                            state_q    <= ST_EMPTY;
                            ev_src_q   <= 2'd0;
                            ev_value_q <= 4'd0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    ev_src_q   <= 2'd0;
                    ev_value_q <= 4'd0;
                end
            endcase
        end
    end

    assign ev_valid  = (state_q == ST_FULL);
    assign ev_src    = ev_src_q;
    assign ev_value  = ev_value_q;
    assign rej_pulse = rej_q;
    assign ovf       = ovf_q;
    assign busy      = (|pending) || (state_q == ST_FULL);

endmodule
`default_nettype wire

// File: tb/tb_coin_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_event_arbiter
// Purpose  : Directed self-checking bench for coin_event_arbiter. Inputs are
//            changed and outputs sampled 1 time unit after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_event_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] coin_pulse;
    logic       accept_en;
    logic       ev_ready;
    logic       ovf_clr;
    logic       ev_valid;
    logic [1:0] ev_src;
    logic [3:0] ev_value;
    logic [3:0] rej_pulse;
    logic [3:0] ovf;
    logic       busy;

    int n_checks;
    int n_fail;

    coin_event_arbiter #(.PEND_W(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .coin_pulse (coin_pulse),
        .accept_en  (accept_en),
        .ev_ready   (ev_ready),
        .ovf_clr    (ovf_clr),
        .ev_valid   (ev_valid),
        .ev_src     (ev_src),
        .ev_value   (ev_value),
        .rej_pulse  (rej_pulse),
        .ovf        (ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presented event as {valid, src, value} for compact comparisons.
    function automatic int ev_word();
        return {23'd0, ev_valid, ev_src, ev_value};
    endfunction

    function automatic int mk_ev(input int v, input int s, input int val);
        return (v << 6) | (s << 4) | val;
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        coin_pulse = 4'd0;
        accept_en  = 1'b1;
        ev_ready   = 1'b1;
        ovf_clr    = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int srcs[4];
        int vals[4];
        int ones;
        n_checks = 0;
        n_fail   = 0;
        srcs = '{0, 1, 2, 3};
        vals = '{1, 2, 5, 10};

        // ---------------- reset state
        do_reset();
        chk("rst_ev", ev_word(), 0);
        chk("rst_rej", int'(rej_pulse), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_busy", int'(busy), 0);

        // ---------------- single coin on source 2
        coin_pulse = 4'b0100;
        tick();
        coin_pulse = 4'd0;
        chk("single_lat0", ev_word(), 0);
        chk("single_busy_pend", int'(busy), 1);
        tick();
        chk("single_ev", ev_word(), mk_ev(1, 2, 5));
        tick();
        chk("single_done", ev_word(), 0);
        chk("single_idle", int'(busy), 0);

        // ---------------- all four sources at once
        do_reset();
        coin_pulse = 4'b1111;
        tick();
        coin_pulse = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("simul_ev%0d", i), ev_word(), mk_ev(1, srcs[i], vals[i]));
        end
        tick();
        chk("simul_done", ev_word(), 0);
        chk("simul_idle", int'(busy), 0);

        // ---------------- backpressure and overflow
        do_reset();
        ev_ready   = 1'b0;
        coin_pulse = 4'b1000;
        tick();
        coin_pulse = 4'd0;
        tick();
        chk("bp_hold_load", ev_word(), mk_ev(1, 3, 10));
        for (int i = 0; i < 4; i++) begin
            coin_pulse = 4'b0001;
            tick();
            coin_pulse = 4'd0;
            chk($sformatf("bp_frozen%0d", i), ev_word(), mk_ev(1, 3, 10));
            chk($sformatf("bp_ovf%0d", i), int'(ovf), (i == 3) ? 1 : 0);
        end
        ev_ready = 1'b1;
        ones = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ev_valid && ev_value == 4'd1) ones++;
        end
        chk("bp_ones", ones, 3);
        chk("bp_drained", int'(busy), 0);
        chk("bp_ovf_sticky", int'(ovf), 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(ovf), 0);

        // ---------------- reject while disabled
        do_reset();
        accept_en  = 1'b0;
        coin_pulse = 4'b1000;
        tick();
        coin_pulse = 4'd0;
        chk("rej_pulse", int'(rej_pulse), 8);
        chk("rej_ev", ev_word(), 0);
        chk("rej_busy", int'(busy), 0);
        tick();
        chk("rej_once", int'(rej_pulse), 0);
        chk("rej_no_ev", ev_word(), 0);
        chk("rej_ovf", int'(ovf), 0);

        // ---------------- round-robin fairness
        do_reset();
        for (int i = 0; i < 9; i++) begin
            coin_pulse = (i < 4) ? 4'b0011 : 4'b0000;
            tick();
            if (i >= 1) begin
                chk($sformatf("rr_ev%0d", i - 1), ev_word(),
                    mk_ev(1, (i - 1) % 2, ((i - 1) % 2 == 0) ? 1 : 2));
            end
        end
        coin_pulse = 4'd0;
        tick();
        chk("rr_done", ev_word(), 0);
        chk("rr_ovf", int'(ovf), 0);

        // ---------------- reset mid-stream
        do_reset();
        ev_ready   = 1'b0;
        coin_pulse = 4'b0011;
        tick();
        coin_pulse = 4'd0;
        tick();
        chk("mid_full", ev_word(), mk_ev(1, 0, 1));
        rst        = 1'b1;
        coin_pulse = 4'b0100;
        tick();
        rst        = 1'b0;
        coin_pulse = 4'd0;
        chk("mid_rst_ev", ev_word(), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_ovf", int'(ovf), 0);
        tick();
        chk("mid_coin_ignored", int'(busy), 0);
        ev_ready   = 1'b1;
        coin_pulse = 4'b0010;
        tick();
        coin_pulse = 4'd0;
        tick();
        chk("mid_next_ev", ev_word(), mk_ev(1, 1, 2));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
